// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// md_sched : multi-cycle MULT/DIV scheduler with HI/LO commit and D-stage stall
// Rev 1.0
// ============================================================================
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    localparam logic [3:0] C_MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] C_DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic        r_sign;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_issue_md;

    always_comb begin
        w_prod = 64'd0;
        if (r_sign) begin
            w_prod = $signed({{32{r_opa[31]}}, r_opa}) * $signed({{32{r_opb[31]}}, r_opb});
        end else begin
            w_prod = {32'd0, r_opa} * {32'd0, r_opb};
        end
    end

    // A zero divisor never commits, so keep the divider output defined instead of X.
    always_comb begin
        w_quo = 32'd0;
        w_rem = 32'd0;
        if (r_opb != 32'd0) begin
            if (r_sign) begin
                w_quo = $signed(r_opa) / $signed(r_opb);
                w_rem = $signed(r_opa) % $signed(r_opb);
            end else begin
                w_quo = r_opa / r_opb;
                w_rem = r_opa % r_opb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_sign  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            C_OP_MULT, C_OP_MULTU: begin
                                r_opa   <= rs_val;
                                r_opb   <= rt_val;
                                r_sign  <= (md_op == C_OP_MULT);
                                r_cnt   <= C_MUL_LOAD;
                                r_state <= S_MUL;
                            end
                            C_OP_DIV, C_OP_DIVU: begin
                                r_opa   <= rs_val;
                                r_opb   <= rt_val;
                                r_sign  <= (md_op == C_OP_DIV);
                                r_cnt   <= C_DIV_LOAD;
                                r_state <= S_DIV;
                            end
                            C_OP_MTHI: r_hi <= rs_val;
                            C_OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_opb != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The issuing op itself must hold off a HI/LO user in D before busy rises.
    assign w_issue_md = start && (md_op >= C_OP_MULT) && (md_op <= C_OP_DIVU);

    assign busy     = (r_state != S_IDLE);
    assign stall_md = d_is_md && (busy || w_issue_md);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// tb_md_sched : self-checking bench for md_sched against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_md_sched;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sched #(
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sign-magnitude model: unsigned arithmetic on magnitudes, sign applied afterwards.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [63:0] p;
        ma = (s && a[31]) ? (~a + 32'd1) : a;
        mb = (s && b[31]) ? (~b + 32'd1) : b;
        p  = {32'd0, ma} * {32'd0, mb};
        return (s && (a[31] ^ b[31])) ? (~p + 64'd1) : p;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = (s && a[31]) ? (~a + 32'd1) : a;
        mb = (s && b[31]) ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (s && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, input int inject);
        int          n;
        bit          sgn;
        logic [63:0] res;
        n   = (op <= 3'd2) ? MULC : DIVC;
        sgn = (op == 3'd1) || (op == 3'd3);
        if (op <= 3'd2)      res = ref_mul(a, b, sgn);
        else if (b != 32'd0) res = ref_div(a, b, sgn);
        else                 res = {m_hi, m_lo};
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_is_md = d;
        #1 check("stall_issue", stall_md, d);
        step();
        start = 1'b0; md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
        for (int i = 1; i <= n; i++) begin
            if (i == inject) begin
                start = 1'b1; md_op = 3'd3; rs_val = $urandom; rt_val = 32'd3;
            end
            #1;
            check("busy_window", busy, 1'b1);
            check("stall_busy", stall_md, d);
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            step();
            start = 1'b0; md_op = 3'd0;
        end
        m_hi = res[63:32];
        m_lo = res[31:0];
        check("busy_fall", busy, 1'b0);
        check("stall_after", stall_md, 1'b0);
        check("commit_hi", hi, m_hi);
        check("commit_lo", lo, m_lo);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        start = 1'b1; md_op = op; rs_val = v; d_is_md = 1'b1;
        #1 check("stall_mt", stall_md, 1'b0);
        step();
        start = 1'b0; md_op = 3'd0;
        if (op == 3'd5) m_hi = v;
        else            m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        d;

        rst_n = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b0;
        #2 rst_n = 1'b0; d_is_md = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", stall_md, 1'b0);
        m_hi = 32'd0; m_lo = 32'd0;
        step(); step();
        #2 rst_n = 1'b1;
        step();

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd2, 1'b0, 0);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        run_op(3'd3, $urandom, 32'd0, 1'b1, 0);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        run_op(3'd1, 32'h1234, 32'h10, 1'b1, 2);
        check("ignored_hi", hi, 32'd0);
        check("ignored_lo", lo, 32'h12340);

        // Abort a DIV in its third busy cycle with an asynchronous reset.
        start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; d_is_md = 1'b1;
        step();
        start = 1'b0; md_op = 3'd0;
        step(); step();
        #1 rst_n = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_stall", stall_md, 1'b0);
        #2 rst_n = 1'b1;
        step();
        mt(3'd6, 32'h5);
        check("post_rst_lo", lo, 32'h5);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            d  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            case (op)
                3'd1, 3'd2, 3'd3, 3'd4: run_op(op, a, b, d, 0);
                3'd5, 3'd6:             mt(op, a);
                default: begin
                    start = 1'b1; md_op = op; rs_val = a; d_is_md = d;
                    #1 check("stall_nop", stall_md, 1'b0);
                    step();
                    start = 1'b0; md_op = 3'd0;
                    check("nop_busy", busy, 1'b0);
                    check("nop_hi", hi, m_hi);
                    check("nop_lo", lo, m_lo);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
